// File: rtl/imm_encoder_if.sv
// Valid/ready bundle between an immediate-encoder client (master) and imm_encoder (slave).
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_src;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  out_err;

  modport master (
    output in_valid, in_imm, in_src, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_src, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into instr[31:7] of a base instruction through a 2-entry output buffer.
// Optional pop statistics (cnt_ok/cnt_err) are built only when IMM_ENC_COUNT_EN is defined.
module imm_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_encoder_if.slave   bus
`ifdef IMM_ENC_COUNT_EN
  ,
  output logic [COUNT_W-1:0] cnt_ok,
  output logic [COUNT_W-1:0] cnt_err
`endif
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t        occ_q, occ_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [2:0]  head_err_q, head_err_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [2:0]  tail_err_q, tail_err_d;

  logic [31:0] enc_instr;
  logic [2:0]  enc_err;
  logic [24:0] enc_field;
  logic        hi11_uniform, hi12_uniform, hi20_uniform;
  logic        push, pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // An upper slice that is all-ones or all-zeros is a faithful sign extension.
  assign hi11_uniform = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
  assign hi12_uniform = (&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]);
  assign hi20_uniform = (&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]);

  always_comb begin
    enc_field = 25'd0;
    enc_err   = 3'b000;
    enc_instr = 32'd0;
    case (bus.in_src)
      IMM_I: begin
        enc_field  = {bus.in_imm[11:0], bus.in_base[19:7]};
        enc_err[0] = ~hi11_uniform;
      end
      IMM_S: begin
        enc_field  = {bus.in_imm[11:5], bus.in_base[24:12], bus.in_imm[4:0]};
        enc_err[0] = ~hi11_uniform;
      end
      IMM_B: begin
        enc_field  = {bus.in_imm[12], bus.in_imm[10:5], bus.in_base[24:12],
                      bus.in_imm[4:1], bus.in_imm[11]};
        enc_err[0] = ~hi12_uniform;
        enc_err[1] = bus.in_imm[0];
      end
      IMM_J: begin
        enc_field  = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                      bus.in_imm[19:12], bus.in_base[11:7]};
        enc_err[0] = ~hi20_uniform;
        enc_err[1] = bus.in_imm[0];
      end
      IMM_U: begin
        enc_field  = {bus.in_imm[31:12], bus.in_base[11:7]};
        enc_err[0] = |bus.in_imm[11:0];
      end
      default: begin
        enc_err = 3'b100;
      end
    endcase
    enc_instr = enc_err[2] ? bus.in_base : {enc_field, bus.in_base[6:0]};
  end

  // Occupancy FSM; a simultaneous push and pop in ONE replaces the head in place.
  always_comb begin
    occ_d        = occ_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    case (occ_q)
      EMPTY: begin
        if (push) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
          occ_d        = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
        end else if (push) begin
          tail_instr_d = enc_instr;
          tail_err_d   = enc_err;
          occ_d        = TWO;
        end else if (pop) begin
          occ_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
          occ_d        = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
    out_valid_d = (occ_d != EMPTY);
    in_ready_d  = (occ_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q        <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      head_instr_q <= 32'd0;
      head_err_q   <= 3'b000;
      tail_instr_q <= 32'd0;
      tail_err_q   <= 3'b000;
    end else begin
      occ_q        <= occ_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = head_instr_q;
  assign bus.out_err   = head_err_q;

`ifdef IMM_ENC_COUNT_EN
  logic [COUNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [COUNT_W-1:0] cnt_err_q, cnt_err_d;

  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (pop) begin
      if (head_err_q == 3'b000) cnt_ok_d  = cnt_ok_q + 1'b1;
      else                      cnt_err_d = cnt_err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_err = cnt_err_q;
`endif

endmodule
